seven_segment_scan_driver: RTL

Time-multiplexed 4-digit seven-segment scan driver, directly downstream of the binary-to-BCD converter. It takes the BCD ones/tens/hundreds of the 8-bit LFSR value and drives the shared segment bus and the anode enables one digit at a time. It has a refresh prescaler, a digit scan counter, a tear-free frame-boundary load, leading-zero blanking and invalid-code detection. All outputs are registered.

---
 rtl/seven_segment_scan_driver_if.sv | 35 +++
 rtl/seven_segment_scan_driver.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seven_segment_scan_driver_if
// Bundles the digit load inputs and the display outputs of the scan driver.
//   load       : single-cycle strobe, digits captured when high
//   ones/tens  : BCD units/tens digit (4 bits each)
//   hundreds   : BCD hundreds digit (0..2, 2 bits)
//   seg        : active-low segments {g,f,e,d,c,b,a}
//   an         : active-low anodes, an[0]=units .. an[3]=unused digit
//   frame_done : one-cycle pulse after each frame boundary
//   dbg_idx    : current digit scan index, for observation only
//
// Handshake: load is valid-only with an implicit ready that is always high.
// Every cycle with load=1 is one accepted transfer of {hundreds,tens,ones};
// there is no back-pressure and no acknowledge.
// -----------------------------------------------------------------------------
interface seven_segment_scan_driver_if;
   logic       load;
   logic [3:0] ones;
   logic [3:0] tens;
   logic [1:0] hundreds;
   logic [6:0] seg;
   logic [3:0] an;
   logic       frame_done;
   logic [1:0] dbg_idx;

   modport master (
      output load, ones, tens, hundreds,
      input  seg, an, frame_done, dbg_idx
   );

   modport slave (
      input  load, ones, tens, hundreds,
      output seg, an, frame_done, dbg_idx
   );
endinterface

// File: rtl/seven_segment_scan_driver.sv
// -----------------------------------------------------------------------------
// seven_segment_scan_driver
// Time-multiplexed 4-digit seven-segment scan driver. A prescaler produces one
// tick every REFRESH_DIV cycles; each tick advances the digit index 0..3.
// New digit values are held pending and only reach the display registers at
// the 3->0 frame boundary, so a frame never shows a mix of old and new digits.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : slave side of seven_segment_scan_driver_if (load/digits in,
//           seg/an/frame_done/dbg_idx out, all outputs registered)
// -----------------------------------------------------------------------------
module seven_segment_scan_driver #(
   parameter int REFRESH_DIV   = 100000,
   parameter bit BLANK_LEADING = 1'b1
) (
   input logic                         clk,
   input logic                         reset,
   seven_segment_scan_driver_if.slave  bus
);

   localparam int              PW        = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0]   PRESC_MAX = PW'(REFRESH_DIV - 1);

   // Digit scan index encodings
   localparam logic [1:0] IDX_UNITS    = 2'd0;
   localparam logic [1:0] IDX_TENS     = 2'd1;
   localparam logic [1:0] IDX_HUNDREDS = 2'd2;
   localparam logic [1:0] IDX_SPARE    = 2'd3;

   logic [PW-1:0] presc_q, presc_d;
   logic [1:0]    idx_q, idx_d;
   logic [9:0]    disp_q, disp_d;   // {hundreds[1:0], tens[3:0], ones[3:0]}
   logic [9:0]    pend_q, pend_d;
   logic          pend_flag_q, pend_flag_d;
   logic [6:0]    seg_q, seg_d;
   logic [3:0]    an_q, an_d;
   logic          frame_done_q, frame_done_d;

   logic          tick;
   logic          boundary;
   logic [9:0]    in_val;
   logic [3:0]    digit;
   logic          blank;

   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b0111111;   // non-BCD code shows a dash
      endcase
      return s;
   endfunction

   always_comb begin
      in_val       = {bus.hundreds, bus.tens, bus.ones};
      tick         = (presc_q == PRESC_MAX);
      boundary     = tick && (idx_q == IDX_SPARE);

      presc_d      = tick ? '0 : presc_q + PW'(1);
      idx_d        = tick ? idx_q + 2'd1 : idx_q;
      frame_done_d = boundary;

      pend_d       = pend_q;
      pend_flag_d  = pend_flag_q;
      disp_d       = disp_q;

      if (boundary) begin
         // A load coinciding with the boundary bypasses the pending stage.
         if (bus.load) begin
            disp_d      = in_val;
            pend_flag_d = 1'b0;
         end else if (pend_flag_q) begin
            disp_d      = pend_q;
            pend_flag_d = 1'b0;
         end
      end else if (bus.load) begin
         pend_d      = in_val;
         pend_flag_d = 1'b1;
      end

      // Digit selection and blanking work from the display registers only.
      case (idx_q)
         IDX_UNITS: begin
            digit = disp_q[3:0];
            blank = 1'b0;
         end
         IDX_TENS: begin
            digit = disp_q[7:4];
            blank = BLANK_LEADING && (disp_q[9:8] == 2'd0) && (disp_q[7:4] == 4'd0);
         end
         IDX_HUNDREDS: begin
            digit = {2'b00, disp_q[9:8]};
            blank = BLANK_LEADING && (disp_q[9:8] == 2'd0);
         end
         default: begin
            digit = 4'd0;
            blank = 1'b1;
         end
      endcase

      an_d  = blank ? 4'b1111 : ~(4'b0001 << idx_q);
      seg_d = blank ? 7'b1111111 : decode(digit);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc_q      <= '0;
         idx_q        <= IDX_UNITS;
         disp_q       <= '0;
         pend_q       <= '0;
         pend_flag_q  <= 1'b0;
         seg_q        <= 7'b1111111;
         an_q         <= 4'b1111;
         frame_done_q <= 1'b0;
      end else begin
         presc_q      <= presc_d;
         idx_q        <= idx_d;
         disp_q       <= disp_d;
         pend_q       <= pend_d;
         pend_flag_q  <= pend_flag_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign bus.seg        = seg_q;
   assign bus.an         = an_q;
   assign bus.frame_done = frame_done_q;
   assign bus.dbg_idx    = idx_q;

endmodule
